// File: rtl/pipe_stage_reg.sv
// Parametrised MIPS pipeline boundary register: payload plus PC+4, ExcCode, delay-slot and valid sideband.
// Optional stall/bubble performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned DW             = 32,
  parameter logic [31:0] PC4_RESET      = 32'h0000_3004,
  parameter logic [31:0] PC4_FLUSH      = 32'h0000_4184,
  parameter bit          KEEP_PC_ON_CLR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          EN,
  input  logic          CLR,
  input  logic          FLUSH,
  input  logic [DW-1:0] data_in,
  input  logic [31:0]   pc_4_in,
  input  logic [6:2]    exc_in,
  input  logic [6:2]    exc_new_in,
  input  logic          bd_in,
  input  logic          valid_in,
  output logic [DW-1:0] data_out,
  output logic [31:0]   pc_4_out,
  output logic [6:2]    exc_out,
  output logic          bd_out,
  output logic          valid_out,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   bubble_cnt
);

  localparam int unsigned CW = 32;

  logic [DW-1:0] data_q, data_d;
  logic [31:0]   pc_4_q, pc_4_d;
  logic [6:2]    exc_q, exc_d;
  logic          bd_q, bd_d;
  logic          valid_q, valid_d;
  logic [6:2]    exc_merged;

  // Older exception wins; a non-instruction slot never carries an ExcCode.
  always_comb begin
    exc_merged = 5'(0);
    if (valid_in) begin
      exc_merged = (exc_in != 5'(0)) ? exc_in : exc_new_in;
    end
  end

  // Next-state selection: FLUSH > CLR > hold > load.
  always_comb begin
    data_d  = data_q;
    pc_4_d  = pc_4_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    if (FLUSH) begin
      data_d  = DW'(0);
      pc_4_d  = PC4_FLUSH;
      exc_d   = 5'(0);
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (CLR) begin
      data_d  = DW'(0);
      exc_d   = 5'(0);
      valid_d = 1'b0;
      pc_4_d  = KEEP_PC_ON_CLR ? pc_4_in : 32'(0);
      bd_d    = KEEP_PC_ON_CLR ? bd_in : 1'b0;
    end else if (EN) begin
      data_d  = data_in;
      pc_4_d  = pc_4_in;
      exc_d   = exc_merged;
      bd_d    = bd_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= DW'(0);
      pc_4_q  <= PC4_RESET;
      exc_q   <= 5'(0);
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      pc_4_q  <= pc_4_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign pc_4_out  = pc_4_q;
  assign exc_out   = exc_q;
  assign bd_out    = bd_q;
  assign valid_out = valid_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters: a held real instruction is a stall, a CLR without FLUSH is a bubble.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!EN && !CLR && !FLUSH && valid_q && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
    if (CLR && !FLUSH && (bubble_cnt_q != {CW{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= CW'(0);
      bubble_cnt_q <= CW'(0);
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = CW'(0);
  assign bubble_cnt = CW'(0);
`endif

endmodule
